// File: rtl/ub_port_arbiter.sv
// ub_port_arbiter: shares the single unified-buffer port among NUM_REQ requesters.
// Arbitration is round-robin with burst locking. Read data comes back RD_LATENCY cycles
// after the accepted read beat and is steered to the requester that issued it.
// Optional build macro: UB_ARB_HOST_PRIO_EN gives requester 0 priority at every IDLE arbitration.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef BUFFER_WIDTH
`define BUFFER_WIDTH 32
`endif

module ub_port_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int RD_LATENCY   = 1,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ-1:0]                    req_wr_en,
  input  logic [NUM_REQ-1:0]                    req_last,
  input  logic [NUM_REQ*`ADDR_WIDTH-1:0]        req_addr,
  input  logic [NUM_REQ*`BUFFER_WIDTH-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]                    req_gnt,
  output logic [NUM_REQ-1:0]                    rsp_valid,
  output logic [`BUFFER_WIDTH-1:0]              rsp_rdata,
  output logic                                  ub_req,
  output logic                                  ub_wr_en,
  output logic [`ADDR_WIDTH-1:0]                ub_addr,
  output logic [`BUFFER_WIDTH-1:0]              ub_wdata,
  input  logic [`BUFFER_WIDTH-1:0]              ub_rdata,
  output logic                                  arb_busy,
  output logic [$clog2(NUM_REQ)-1:0]            arb_owner,
  output logic                                  lock_timeout
);

  localparam int AW    = `ADDR_WIDTH;
  localparam int BW    = `BUFFER_WIDTH;
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(LOCK_TIMEOUT);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   idle_q, idle_d;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic               gnt_any;
  logic [IDX_W-1:0]   gnt_idx;
  logic               rd_beat;
  logic               vld_p [RD_LATENCY];
  logic [IDX_W-1:0]   id_p  [RD_LATENCY];

  // Wraps a requester index to the next one, modulo NUM_REQ.
  function automatic logic [IDX_W-1:0] inc_mod(input logic [IDX_W-1:0] i);
    if (int'(i) == NUM_REQ - 1) return '0;
    return i + 1'b1;
  endfunction

  // Winner of an IDLE arbitration: first valid requester at or after rr_ptr.
  always_comb begin
    int j;
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(rr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req_valid[j]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(j);
      end
    end
`ifdef UB_ARB_HOST_PRIO_EN
    if (req_valid[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
`endif
  end

  // Next-state, grant and lock-timeout logic; everything is held low while in reset.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    owner_d      = owner_q;
    idle_d       = idle_q;
    gnt_any      = 1'b0;
    gnt_idx      = owner_q;
    lock_timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_any = 1'b1;
          gnt_idx = win_idx;
          idle_d  = '0;
          if (req_last[win_idx]) begin
            rr_d = inc_mod(win_idx);
          end else begin
            state_d = LOCKED;
            owner_d = win_idx;
          end
        end
      end
      LOCKED: begin
        if (req_valid[owner_q]) begin
          gnt_any = 1'b1;
          gnt_idx = owner_q;
          idle_d  = '0;
          if (req_last[owner_q]) begin
            state_d = IDLE;
            rr_d    = inc_mod(owner_q);
          end
        end else if (idle_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_d      = IDLE;
          rr_d         = inc_mod(owner_q);
          idle_d       = '0;
          lock_timeout = 1'b1;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    gnt_any      = gnt_any & rst_n;
    lock_timeout = lock_timeout & rst_n;
  end

  // Arbiter control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      idle_q  <= idle_d;
    end
  end

  // UB port mux from the granted requester; all zero when no beat transfers.
  always_comb begin
    req_gnt  = '0;
    ub_req   = 1'b0;
    ub_wr_en = 1'b0;
    ub_addr  = '0;
    ub_wdata = '0;
    if (gnt_any) begin
      req_gnt  = NUM_REQ'(1) << gnt_idx;
      ub_req   = 1'b1;
      ub_wr_en = req_wr_en[gnt_idx];
      ub_addr  = req_addr[int'(gnt_idx)*AW +: AW];
      ub_wdata = req_wdata[int'(gnt_idx)*BW +: BW];
    end
  end

  assign rd_beat = gnt_any & ~req_wr_en[gnt_idx];

  // ---- read-return pipe: stage p0 loads on an accepted read, last stage drives rsp_valid ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        vld_p[i] <= 1'b0;
        id_p[i]  <= '0;
      end
    end else begin
      vld_p[0] <= rd_beat;
      id_p[0]  <= gnt_idx;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
        id_p[i]  <= id_p[i-1];
      end
    end
  end

  assign rsp_valid = vld_p[RD_LATENCY-1] ? (NUM_REQ'(1) << id_p[RD_LATENCY-1]) : '0;
  assign rsp_rdata = rst_n ? ub_rdata : '0;
  assign arb_busy  = (state_q == LOCKED);
  assign arb_owner = owner_q;

endmodule

// File: tb/tb_ub_port_arbiter.sv
// Directed testbench for ub_port_arbiter: one instance at RD_LATENCY=1 and one at
// RD_LATENCY=2 share the same stimulus.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef BUFFER_WIDTH
`define BUFFER_WIDTH 32
`endif

module tb_ub_port_arbiter;

  localparam int NR = 3;
  localparam int AW = `ADDR_WIDTH;
  localparam int BW = `BUFFER_WIDTH;
  localparam int LT = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid, req_wr_en, req_last;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*BW-1:0]  req_wdata;
  logic [BW-1:0]     ub_rdata;

  logic [NR-1:0]     req_gnt, rsp_valid;
  logic [BW-1:0]     rsp_rdata, ub_wdata;
  logic              ub_req, ub_wr_en, arb_busy, lock_timeout;
  logic [AW-1:0]     ub_addr;
  logic [1:0]        arb_owner;

  logic [NR-1:0]     d2_req_gnt, d2_rsp_valid;
  logic [BW-1:0]     d2_rsp_rdata, d2_ub_wdata;
  logic              d2_ub_req, d2_ub_wr_en, d2_arb_busy, d2_lock_timeout;
  logic [AW-1:0]     d2_ub_addr;
  logic [1:0]        d2_arb_owner;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ub_port_arbiter #(.NUM_REQ(NR), .RD_LATENCY(1), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_wr_en(req_wr_en),
    .req_last(req_last), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_gnt(req_gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ub_req(ub_req), .ub_wr_en(ub_wr_en), .ub_addr(ub_addr), .ub_wdata(ub_wdata),
    .ub_rdata(ub_rdata), .arb_busy(arb_busy), .arb_owner(arb_owner),
    .lock_timeout(lock_timeout)
  );

  ub_port_arbiter #(.NUM_REQ(NR), .RD_LATENCY(2), .LOCK_TIMEOUT(LT)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_wr_en(req_wr_en),
    .req_last(req_last), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_gnt(d2_req_gnt), .rsp_valid(d2_rsp_valid), .rsp_rdata(d2_rsp_rdata),
    .ub_req(d2_ub_req), .ub_wr_en(d2_ub_wr_en), .ub_addr(d2_ub_addr), .ub_wdata(d2_ub_wdata),
    .ub_rdata(ub_rdata), .arb_busy(d2_arb_busy), .arb_owner(d2_arb_owner),
    .lock_timeout(d2_lock_timeout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic wr, input logic last,
                         input logic [AW-1:0] a, input logic [BW-1:0] d);
    req_valid[i] = v;
    req_wr_en[i] = wr;
    req_last[i]  = last;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*BW +: BW] = d;
  endtask

  task automatic clear_all();
    req_valid = '0;
    req_wr_en = '0;
    req_last  = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  int to_pulses;
  int stray_gnt;
  int late_rsp;

  initial begin
    rst_n    = 1'b0;
    clear_all();
    ub_rdata = '0;
    req_valid = 3'b111;
    req_last  = 3'b111;

    // Reset: outputs zero even with requests pending
    @(negedge clk);
    chk("rst_gnt", req_gnt, 0);
    chk("rst_ub_req", ub_req, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_busy", arb_busy, 0);
    chk("rst_owner", arb_owner, 0);
    chk("rst_to", lock_timeout, 0);
    tick();
    clear_all();
    rst_n = 1'b1;

    // 1: single read by req 1 at 0x10
    set_req(1, 1, 0, 1, 16'h0010, '0);
    @(negedge clk);
    chk("t1_gnt", req_gnt, 3'b010);
    chk("t1_ub_req", ub_req, 1);
    chk("t1_ub_wr", ub_wr_en, 0);
    chk("t1_addr", ub_addr, 16'h0010);
    tick();
    clear_all();
    ub_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    chk("t1_rsp", rsp_valid, 3'b010);
    chk("t1_rdata", rsp_rdata, 32'hA5A5A5A5);
    chk("t1_d2_rsp_early", d2_rsp_valid, 3'b000);
    chk("t1_idle_gnt", req_gnt, 3'b000);
    chk("t1_idle_addr", ub_addr, 16'h0000);
    tick();
    @(negedge clk);
    chk("t1_rsp_done", rsp_valid, 3'b000);
    chk("t1_d2_rsp", d2_rsp_valid, 3'b010);
    tick();

    // rr_ptr is now 2: single write from req 2 brings it back to 0
    set_req(2, 1, 1, 1, 16'h0002, 32'hCAFE0002);
    @(negedge clk);
    chk("t2_pre_gnt", req_gnt, 3'b100);
    chk("t2_pre_wdata", ub_wdata, 32'hCAFE0002);
    chk("t2_pre_wr", ub_wr_en, 1);
    tick();

    // 2: all three valid, single-beat writes
    set_req(0, 1, 1, 1, 16'h0100, 32'h00000000);
    set_req(1, 1, 1, 1, 16'h0101, 32'h11111111);
    set_req(2, 1, 1, 1, 16'h0102, 32'h22222222);
`ifdef UB_ARB_HOST_PRIO_EN
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t2_prio_gnt", req_gnt, 3'b001);
      tick();
    end
`else
    @(negedge clk); chk("t2_gnt_a", req_gnt, 3'b001); chk("t2_addr_a", ub_addr, 16'h0100); tick();
    @(negedge clk); chk("t2_gnt_b", req_gnt, 3'b010); chk("t2_addr_b", ub_addr, 16'h0101); tick();
    @(negedge clk); chk("t2_gnt_c", req_gnt, 3'b100); chk("t2_data_c", ub_wdata, 32'h22222222); tick();
    @(negedge clk); chk("t2_gnt_d", req_gnt, 3'b001); tick();
`endif
    clear_all();

    // 3: req 2 burst of 4 writes, req 0 arrives mid-burst (rr_ptr is 1)
    set_req(2, 1, 1, 0, 16'h0200, 32'hB0000001);
    @(negedge clk);
    chk("t3_b1_gnt", req_gnt, 3'b100);
    chk("t3_b1_busy", arb_busy, 0);
    tick();
    set_req(0, 1, 1, 1, 16'h0300, 32'h00000300);
    for (int b = 2; b <= 4; b++) begin
      set_req(2, 1, 1, (b == 4), 16'(16'h0200 + b - 1), 32'(32'hB0000000 + b));
      @(negedge clk);
      chk("t3_burst_gnt", req_gnt, 3'b100);
      chk("t3_burst_busy", arb_busy, 1);
      chk("t3_burst_owner", arb_owner, 2);
      chk("t3_burst_wdata", ub_wdata, 32'(32'hB0000000 + b));
      tick();
    end
    set_req(2, 0, 0, 0, '0, '0);
    @(negedge clk);
    chk("t3_host_gnt", req_gnt, 3'b001);
    chk("t3_host_busy", arb_busy, 0);
    chk("t3_host_addr", ub_addr, 16'h0300);
    tick();
    clear_all();

    // 4: req 1 locks then goes idle; req 2 waits (rr_ptr is 1)
    set_req(1, 1, 1, 0, 16'h0400, 32'h44440000);
    @(negedge clk);
    chk("t4_lock_gnt", req_gnt, 3'b010);
    tick();
    clear_all();
    set_req(2, 1, 1, 1, 16'h0500, 32'h55550000);
    to_pulses = 0;
    stray_gnt = 0;
    for (int k = 1; k < LT; k++) begin
      @(negedge clk);
      if (lock_timeout) to_pulses++;
      if (req_gnt != 0) stray_gnt++;
      tick();
    end
    chk("t4_no_early_to", to_pulses, 0);
    chk("t4_no_stray_gnt", stray_gnt, 0);
    @(negedge clk);
    chk("t4_to_pulse", lock_timeout, 1);
    chk("t4_to_gnt", req_gnt, 3'b000);
    chk("t4_to_busy", arb_busy, 1);
    tick();
    @(negedge clk);
    chk("t4_after_to", lock_timeout, 0);
    chk("t4_after_busy", arb_busy, 0);
    chk("t4_after_gnt", req_gnt, 3'b100);
    tick();
    clear_all();

    // 5: back-to-back reads from 0 then 1 (rr_ptr is 0)
    set_req(0, 1, 0, 1, 16'h0020, '0);
    set_req(1, 1, 0, 1, 16'h0030, '0);
    @(negedge clk);
    chk("t5_gnt0", req_gnt, 3'b001);
    chk("t5_addr0", ub_addr, 16'h0020);
    tick();
    set_req(0, 0, 0, 0, '0, '0);
    @(negedge clk);
    chk("t5_gnt1", req_gnt, 3'b010);
    chk("t5_addr1", ub_addr, 16'h0030);
    chk("t5_lat1_rsp0", rsp_valid, 3'b001);
    chk("t5_d2_none", d2_rsp_valid, 3'b000);
    tick();
    clear_all();
    ub_rdata = 32'h11111111;
    @(negedge clk);
    chk("t5_d2_rsp0", d2_rsp_valid, 3'b001);
    chk("t5_d2_data0", d2_rsp_rdata, 32'h11111111);
    tick();
    ub_rdata = 32'h22222222;
    @(negedge clk);
    chk("t5_d2_rsp1", d2_rsp_valid, 3'b010);
    chk("t5_d2_data1", d2_rsp_rdata, 32'h22222222);
    tick();
    @(negedge clk);
    chk("t5_d2_done", d2_rsp_valid, 3'b000);
    tick();

    // 6: reset mid-burst with a read outstanding (rr_ptr is 2)
    set_req(0, 1, 0, 0, 16'h0600, '0);
    @(negedge clk);
    chk("t6_gnt", req_gnt, 3'b001);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_gnt", req_gnt, 3'b000);
    chk("t6_rst_ub_req", ub_req, 0);
    chk("t6_rst_busy", arb_busy, 0);
    chk("t6_rst_rsp", rsp_valid, 3'b000);
    chk("t6_rst_d2_rsp", d2_rsp_valid, 3'b000);
    chk("t6_rst_rdata", rsp_rdata, 0);
    tick();
    tick();
    clear_all();
    rst_n = 1'b1;
    late_rsp = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (rsp_valid != 0 || d2_rsp_valid != 0) late_rsp++;
      tick();
    end
    chk("t6_no_late_rsp", late_rsp, 0);
    chk("t6_post_busy", arb_busy, 0);
    chk("t6_post_owner", arb_owner, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
